// File: rtl/array_req_sched_pkg.sv
// Shared definitions for the array request scheduler: source encoding,
// frame width derivation and default field widths.
package array_req_sched_pkg;

  localparam int DEF_ADDR_WIDTH  = 20;
  localparam int DEF_DATA_WIDTH  = 64;
  localparam int DEF_QUOTA_WIDTH = 4;

  // Frames carry three control bits on top of the address and data fields.
  localparam int FRAME_CTRL_BITS = 3;

  // Owner / grant encoding shared by the arbiter and the frame register.
  localparam logic SRC_WR = 1'b0;
  localparam logic SRC_RD = 1'b1;

  function automatic int frame_width(input int addr_w, input int data_w);
    return addr_w + data_w + FRAME_CTRL_BITS;
  endfunction

endpackage

// File: rtl/array_req_arb.sv
// Weighted round-robin grant decision between the write and read streams,
// plus the owner / consecutive-grant counter that enforces the burst quotas.
module array_req_arb
  import array_req_sched_pkg::*;
#(
  parameter int QUOTA_WIDTH = DEF_QUOTA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  input  logic                   rd_valid,
  input  logic                   accept,
  input  logic [QUOTA_WIDTH-1:0] wr_quota,
  input  logic [QUOTA_WIDTH-1:0] rd_quota,
  output logic                   grant
);

  localparam logic [QUOTA_WIDTH-1:0] CNT_MAX = {QUOTA_WIDTH{1'b1}};

  logic                   owner;
  logic [QUOTA_WIDTH-1:0] grant_cnt;
  logic [QUOTA_WIDTH-1:0] owner_cfg;
  logic [QUOTA_WIDTH-1:0] eff_quota;

  // Pick the source: a lone requester always wins; under contention the
  // owner keeps the grant until its quota (0 read as 1) is used up.
  always_comb begin
    owner_cfg = (owner == SRC_WR) ? wr_quota : rd_quota;
    eff_quota = (owner_cfg == '0) ? QUOTA_WIDTH'(1) : owner_cfg;
    grant     = SRC_WR;
    if (wr_valid && rd_valid) begin
      grant = (grant_cnt < eff_quota) ? owner : ~owner;
    end else if (rd_valid) begin
      grant = SRC_RD;
    end
  end

  // Track who holds the burst and how many grants it has had in a row;
  // solo grants count too, and the counter saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= SRC_WR;
      grant_cnt <= '0;
    end else if (accept) begin
      if (grant == owner) begin
        if (grant_cnt != CNT_MAX) begin
          grant_cnt <= grant_cnt + QUOTA_WIDTH'(1);
        end
      end else begin
        owner     <= grant;
        grant_cnt <= QUOTA_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/array_req_sched.sv
// Request scheduler: merges the write and read frame streams into a single
// registered valid/ready stream for the array controller.
module array_req_sched
  import array_req_sched_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int AXI_DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int AXI_FRAME_WIDTH = frame_width(AXI_ADDR_WIDTH, AXI_DATA_WIDTH),
  parameter int QUOTA_WIDTH     = DEF_QUOTA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mc_en,
  input  logic [QUOTA_WIDTH-1:0]     sched_wr_quota_cfg,
  input  logic [QUOTA_WIDTH-1:0]     sched_rd_quota_cfg,
  input  logic [AXI_FRAME_WIDTH-1:0] wr_frame_data,
  input  logic                       wr_frame_valid,
  output logic                       wr_frame_ready,
  input  logic [AXI_FRAME_WIDTH-1:0] rd_frame_data,
  input  logic                       rd_frame_valid,
  output logic                       rd_frame_ready,
  output logic [AXI_FRAME_WIDTH-1:0] axi_frame_data,
  output logic                       axi_frame_valid,
  input  logic                       axi_frame_ready,
  output logic                       sched_is_wr,
  output logic                       sched_busy
);

  logic grant;
  logic slot_free;
  logic accept;

  array_req_arb #(
    .QUOTA_WIDTH (QUOTA_WIDTH)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_frame_valid),
    .rd_valid (rd_frame_valid),
    .accept   (accept),
    .wr_quota (sched_wr_quota_cfg),
    .rd_quota (sched_rd_quota_cfg),
    .grant    (grant)
  );

  // The holding register can take a frame when empty or draining this cycle.
  // Readies are gated by rst_n so nothing upstream is consumed during reset.
  assign slot_free      = !axi_frame_valid || axi_frame_ready;
  assign accept         = rst_n && mc_en && slot_free && (wr_frame_valid || rd_frame_valid);
  assign wr_frame_ready = accept && (grant == SRC_WR);
  assign rd_frame_ready = accept && (grant == SRC_RD);
  assign sched_busy     = axi_frame_valid || wr_frame_valid || rd_frame_valid;

  // One-entry output register: load on accept, clear valid on a bare drain,
  // keep data and source flag stable otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi_frame_data  <= '0;
      axi_frame_valid <= 1'b0;
      sched_is_wr     <= 1'b0;
    end else if (accept) begin
      axi_frame_data  <= (grant == SRC_WR) ? wr_frame_data : rd_frame_data;
      axi_frame_valid <= 1'b1;
      sched_is_wr     <= (grant == SRC_WR);
    end else if (axi_frame_ready) begin
      axi_frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_array_req_sched.sv
// Self-checking bench for array_req_sched: directed scenarios plus a
// randomized phase, all compared against a grant-history reference model.
module tb_array_req_sched;

  localparam int FW      = 87;
  localparam int QW      = 4;
  localparam int CNT_MAX = 15;

  logic          clk;
  logic          rst_n;
  logic          mc_en;
  logic [QW-1:0] sched_wr_quota_cfg;
  logic [QW-1:0] sched_rd_quota_cfg;
  logic [FW-1:0] wr_frame_data;
  logic          wr_frame_valid;
  logic          wr_frame_ready;
  logic [FW-1:0] rd_frame_data;
  logic          rd_frame_valid;
  logic          rd_frame_ready;
  logic [FW-1:0] axi_frame_data;
  logic          axi_frame_valid;
  logic          axi_frame_ready;
  logic          sched_is_wr;
  logic          sched_busy;

  array_req_sched dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .mc_en              (mc_en),
    .sched_wr_quota_cfg (sched_wr_quota_cfg),
    .sched_rd_quota_cfg (sched_rd_quota_cfg),
    .wr_frame_data      (wr_frame_data),
    .wr_frame_valid     (wr_frame_valid),
    .wr_frame_ready     (wr_frame_ready),
    .rd_frame_data      (rd_frame_data),
    .rd_frame_valid     (rd_frame_valid),
    .rd_frame_ready     (rd_frame_ready),
    .axi_frame_data     (axi_frame_data),
    .axi_frame_valid    (axi_frame_valid),
    .axi_frame_ready    (axi_frame_ready),
    .sched_is_wr        (sched_is_wr),
    .sched_busy         (sched_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Upstream sources and sink control as the bench sees them.
  logic          wv, rv, en, axr;
  logic [FW-1:0] wd, rd;
  logic [QW-1:0] wq, rq;

  // Reference model: held output slot plus the full history of grants.
  logic          m_valid, m_is_wr;
  logic [FW-1:0] m_data;
  bit            hist[$];
  string         trace;

  function automatic logic [FW-1:0] randFrame();
    logic [FW-1:0] f;
    f[31:0]  = $urandom();
    f[63:32] = $urandom();
    f[86:64] = 23'($urandom());
    return f;
  endfunction

  // Grant from the rules: the owner is whoever was granted last, its count is
  // the length of its latest unbroken run of grants, capped at CNT_MAX.
  function automatic logic modelGrant();
    logic own;
    int   run;
    int   q;
    if (wv && rv) begin
      own = (hist.size() == 0) ? 1'b0 : hist[hist.size()-1];
      run = 0;
      for (int i = hist.size() - 1; i >= 0 && run < CNT_MAX; i--) begin
        if (hist[i] != own) break;
        run++;
      end
      q = own ? int'(rq) : int'(wq);
      if (q == 0) q = 1;
      return (run < q) ? own : ~own;
    end
    return rv ? 1'b1 : 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkTrace(input string tag, input string exp);
    checks++;
    assert (trace == exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: got %s expected %s", tag, trace, exp);
    end
  endtask

  task automatic applyStimulus();
    mc_en              = en;
    sched_wr_quota_cfg = wq;
    sched_rd_quota_cfg = rq;
    wr_frame_valid     = wv;
    wr_frame_data      = wd;
    rd_frame_valid     = rv;
    rd_frame_data      = rd;
    axi_frame_ready    = axr;
  endtask

  // Called on a falling edge: assert reset with the current inputs still
  // presented, check everything is cleared, then release on the next falling edge.
  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus();
    #1;
    checkOutput("rst_valid",  128'(axi_frame_valid), 128'(0));
    checkOutput("rst_data",   128'(axi_frame_data),  128'(0));
    checkOutput("rst_is_wr",  128'(sched_is_wr),     128'(0));
    checkOutput("rst_wr_rdy", 128'(wr_frame_ready),  128'(0));
    checkOutput("rst_rd_rdy", 128'(rd_frame_ready),  128'(0));
    m_valid = 1'b0;
    m_is_wr = 1'b0;
    m_data  = '0;
    hist.delete();
    wv = 1'b0;
    rv = 1'b0;
    applyStimulus();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle starting at a falling edge: refill sources, drive, check
  // registered and combinational outputs, then advance the model.
  task automatic stepCycle(input int wr_pct, input int rd_pct, input int rdy_pct);
    logic g, acc;
    if (!wv && $urandom_range(99) < wr_pct) begin wv = 1'b1; wd = randFrame(); end
    if (!rv && $urandom_range(99) < rd_pct) begin rv = 1'b1; rd = randFrame(); end
    axr = ($urandom_range(99) < rdy_pct);
    applyStimulus();
    #1;
    trace = {trace, axi_frame_valid ? (sched_is_wr ? "W" : "R") : "."};
    acc = en && (!m_valid || axr) && (wv || rv);
    g   = modelGrant();
    checkOutput("out_valid", 128'(axi_frame_valid), 128'(m_valid));
    checkOutput("busy",      128'(sched_busy),      128'(m_valid || wv || rv));
    checkOutput("wr_ready",  128'(wr_frame_ready),  128'(acc && !g));
    checkOutput("rd_ready",  128'(rd_frame_ready),  128'(acc && g));
    if (m_valid) begin
      checkOutput("out_data",  128'(axi_frame_data), 128'(m_data));
      checkOutput("out_is_wr", 128'(sched_is_wr),    128'(m_is_wr));
    end
    if (acc) begin
      m_data  = g ? rd : wd;
      m_valid = 1'b1;
      m_is_wr = ~g;
      hist.push_back(g);
      if (g) rv = 1'b0;
      else   wv = 1'b0;
    end else if (axr) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1; wq = 4'd2; rq = 4'd2; axr = 1'b0;
    wv = 1'b0; rv = 1'b0; wd = '0; rd = '0;
    m_valid = 1'b0; m_is_wr = 1'b0; m_data = '0;
    applyStimulus();
    @(negedge clk);
    doReset();

    $display("[TB] idle after reset");
    repeat (3) stepCycle(0, 0, 100);

    $display("[TB] write only, five frames");
    trace = "";
    repeat (5) stepCycle(100, 0, 100);
    repeat (2) stepCycle(0, 0, 100);
    checkTrace("wr_only_order", ".WWWWW.");

    $display("[TB] both saturated, quotas 2/1");
    wq = 4'd2; rq = 4'd1;
    doReset();
    trace = "";
    repeat (7) stepCycle(100, 100, 100);
    checkTrace("wrr_2_1_order", ".WWRWWR");

    $display("[TB] both saturated, quotas 0/0");
    wq = 4'd0; rq = 4'd0;
    doReset();
    trace = "";
    repeat (7) stepCycle(100, 100, 100);
    checkTrace("wrr_0_0_order", ".WRWRWR");

    $display("[TB] output stall then release");
    wq = 4'd2; rq = 4'd2;
    doReset();
    stepCycle(100, 100, 100);
    repeat (3) stepCycle(100, 100, 0);
    repeat (2) stepCycle(100, 100, 100);

    $display("[TB] enable dropped with a held frame");
    stepCycle(100, 100, 0);
    en = 1'b0;
    repeat (3) stepCycle(100, 100, 100);
    en = 1'b1;
    repeat (4) stepCycle(100, 100, 100);

    $display("[TB] reset mid-stream");
    stepCycle(100, 100, 0);
    doReset();
    repeat (2) stepCycle(100, 100, 100);

    $display("[TB] counter saturation");
    wq = 4'd15; rq = 4'd15;
    doReset();
    repeat (18) stepCycle(100, 0, 100);
    repeat (4) stepCycle(100, 100, 100);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++) begin
      if (i % 60 == 0) begin
        wq = 4'($urandom_range(15));
        rq = 4'($urandom_range(15));
      end
      if (i % 300 == 299) doReset();
      en = ($urandom_range(9) != 0);
      stepCycle($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(20, 100));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
